toggler_bank: RTL and testbench

- Multi-channel successor to the single toggle flip-flop: CHANNELS independent toggle bits.
- Each channel has a runtime-selectable mode: hold, manual toggle, auto toggle from a shared prescaler, or force.
- Per-channel saturating transition counters can be read back through one registered read port.
- Used as the general-purpose flag/blink bank in the prime-search datapath and its benches.

---
 rtl/toggler_bank.sv | 72 +++++++
 tb/tb_toggler_bank.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/toggler_bank.sv
// toggler_bank: bank of mode-selectable toggle bits with shared prescaler and saturating transition counters.
// Define TOGGLER_EDGE_DETECT_EN to make MANUAL mode flip only on rising edges of toggle_i.
module toggler_bank #(
  parameter int CHANNELS = 8,
  parameter int CNT_W = 8,
  parameter int DIV_W = 16,
  parameter int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] toggle_i,
  input  logic                cfg_we_i,
  input  logic [CH_W-1:0]     cfg_ch_i,
  input  logic [1:0]          cfg_mode_i,
  input  logic [DIV_W-1:0]    div_i,
  input  logic                clr_cnt_i,
  input  logic [CH_W-1:0]     rd_ch_i,
  output logic [CHANNELS-1:0] q_o,
  output logic [CNT_W-1:0]    cnt_o,
  output logic                tick_o
);
  localparam logic [1:0] HOLD = 2'd0, MANUAL = 2'd1, AUTO = 2'd2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [1:0]          mode   [CHANNELS];
  logic [CNT_W-1:0]    cnt    [CHANNELS];
  logic [CNT_W-1:0]    cnt_rd [2**CH_W];
  logic [DIV_W-1:0]    pre;
  logic [CHANNELS-1:0] man, q_n;
  logic                wrap;
  assign wrap = pre >= div_i;
`ifdef TOGGLER_EDGE_DETECT_EN
  logic [CHANNELS-1:0] toggle_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) toggle_d <= '0;
    else toggle_d <= toggle_i;
  assign man = toggle_i & ~toggle_d;
`else
  assign man = toggle_i;
`endif
  always_comb begin
    for (int c = 0; c < CHANNELS; c++)
      q_n[c] = mode[c] == HOLD   ? q_o[c] :
               mode[c] == MANUAL ? q_o[c] ^ man[c] :
               mode[c] == AUTO   ? q_o[c] ^ tick_o : toggle_i[c];
  end
  // unused read slots past CHANNELS read back as zero
  always_comb begin
    for (int i = 0; i < 2**CH_W; i++) cnt_rd[i] = '0;
    for (int c = 0; c < CHANNELS; c++) cnt_rd[c] = cnt[c];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q_o <= '0;
      pre <= '0;
      tick_o <= 1'b0;
      cnt_o <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        mode[c] <= MANUAL;
        cnt[c] <= '0;
      end
    end else begin
      q_o <= q_n;
      pre <= wrap ? '0 : pre + DIV_W'(1);
      tick_o <= wrap;
      cnt_o <= cnt_rd[rd_ch_i];
      for (int c = 0; c < CHANNELS; c++) begin
        if (cfg_we_i && cfg_ch_i == CH_W'(c)) mode[c] <= cfg_mode_i;
        cnt[c] <= clr_cnt_i ? '0 :
                  (q_n[c] != q_o[c] && cnt[c] != CNT_MAX) ? cnt[c] + CNT_W'(1) : cnt[c];
      end
    end
endmodule

// File: tb/tb_toggler_bank.sv
// tb_toggler_bank: directed and randomized checks of toggler_bank against an integer reference model.
module tb_toggler_bank;
  localparam int CH = 8, CW = 4, DW = 16, CHW = 3;
  localparam int CMAX = (1 << CW) - 1;
`ifdef TOGGLER_EDGE_DETECT_EN
  localparam bit ED = 1'b1;
`else
  localparam bit ED = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [CH-1:0] toggle_i = '1;
  logic cfg_we_i = 1'b0;
  logic [CHW-1:0] cfg_ch_i = '0;
  logic [1:0] cfg_mode_i = '0;
  logic [DW-1:0] div_i = '0;
  logic clr_cnt_i = 1'b0;
  logic [CHW-1:0] rd_ch_i = '0;
  logic [CH-1:0] q_o;
  logic [CW-1:0] cnt_o;
  logic tick_o;
  int n_vec = 0, n_err = 0;
  int mq [CH], mmode [CH], mcnt [CH], mtd [CH];
  int mpre, mtick, mcnto;

  toggler_bank #(.CHANNELS(CH), .CNT_W(CW), .DIV_W(DW)) dut (
    .clk(clk), .rst(rst), .toggle_i(toggle_i), .cfg_we_i(cfg_we_i), .cfg_ch_i(cfg_ch_i),
    .cfg_mode_i(cfg_mode_i), .div_i(div_i), .clr_cnt_i(clr_cnt_i), .rd_ch_i(rd_ch_i),
    .q_o(q_o), .cnt_o(cnt_o), .tick_o(tick_o));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      mq[c] = 0; mmode[c] = 1; mcnt[c] = 0; mtd[c] = 0;
    end
    mpre = 0; mtick = 0; mcnto = 0;
  endfunction

  function automatic void model_edge();
    int ncnto, ntick, t, man, nq;
    if (rst) begin
      model_reset();
      return;
    end
    ncnto = (int'(rd_ch_i) < CH) ? mcnt[rd_ch_i] : 0;
    ntick = (mpre >= int'(div_i)) ? 1 : 0;
    mpre = ntick ? 0 : mpre + 1;
    for (int c = 0; c < CH; c++) begin
      t = int'(toggle_i[c]);
      man = ED ? (t & (1 - mtd[c])) : t;
      case (mmode[c])
        0: nq = mq[c];
        1: nq = mq[c] ^ man;
        2: nq = mq[c] ^ mtick;
        default: nq = t;
      endcase
      if (nq != mq[c] && mcnt[c] < CMAX) mcnt[c]++;
      if (clr_cnt_i) mcnt[c] = 0;
      mq[c] = nq;
      mtd[c] = t;
    end
    mtick = ntick;
    mcnto = ncnto;
    if (cfg_we_i && int'(cfg_ch_i) < CH) mmode[cfg_ch_i] = int'(cfg_mode_i);
  endfunction

  task automatic cmp();
    logic [CH-1:0] eq;
    for (int c = 0; c < CH; c++) eq[c] = mq[c][0];
    chk("q_o", 32'(q_o), 32'(eq));
    chk("tick_o", 32'(tick_o), 32'(mtick));
    chk("cnt_o", 32'(cnt_o), 32'(mcnto));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cmp();
  endtask

  task automatic cfg(input int ch, input int md);
    cfg_we_i = 1'b1; cfg_ch_i = CHW'(ch); cfg_mode_i = 2'(md);
    step();
    cfg_we_i = 1'b0;
  endtask

  initial begin
    int base, nt, nf;
    logic q2;
    model_reset();
    #1;
    chk("reset_q_async", 32'(q_o), 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("reset_q", 32'(q_o), 0);
      chk("reset_tick", 32'(tick_o), 0);
      chk("reset_cnt", 32'(cnt_o), 0);
    end
    rst = 1'b0;
    step();
    chk("release_q", 32'(q_o), 32'hFF);
    // MANUAL on channel 0: level vs edge behaviour
    rst = 1'b1; toggle_i = '0;
    step();
    rst = 1'b0; toggle_i = 8'h01; rd_ch_i = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("man_q0_hi", 32'(q_o[0]), ED ? 1 : 32'((i + 1) % 2));
    end
    toggle_i = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("man_q0_lo", 32'(q_o[0]), ED ? 1 : 0);
    end
    chk("man_cnt0", 32'(cnt_o), ED ? 1 : 4);
    // AUTO on channel 2 with period 4
    div_i = 3; rd_ch_i = 2;
    cfg(2, 2);
    base = int'(cnt_o); nt = 0; nf = 0; q2 = q_o[2];
    for (int i = 0; i < 12; i++) begin
      step();
      nt += int'(tick_o);
      if (q_o[2] != q2) nf++;
      q2 = q_o[2];
    end
    step();
    chk("auto_ticks", 32'(nt), 3);
    chk("auto_flips", 32'(nf), 3);
    chk("auto_cnt_delta", 32'(int'(cnt_o) - base), 3);
    for (int i = 0; i < 10 && mpre != 2; i++) step();
    chk("pre_reached_2", 32'(mpre), 2);
    div_i = 0;
    step();
    chk("div_drop_tick1", 32'(tick_o), 1);
    step();
    chk("div_drop_tick2", 32'(tick_o), 1);
    // FORCE then HOLD on channel 1
    rd_ch_i = 1;
    cfg(1, 3);
    toggle_i = 8'h02;
    step();
    chk("force_q1", 32'(q_o[1]), 1);
    base = int'(cnt_o);
    step();
    chk("force_cnt", 32'(cnt_o), 32'(base + 1));
    step(); step();
    chk("force_hold_cnt", 32'(cnt_o), 32'(base + 1));
    cfg(1, 0);
    toggle_i = 8'h00; step();
    toggle_i = 8'h02; step();
    toggle_i = 8'h00; step();
    chk("hold_q1", 32'(q_o[1]), 1);
    // saturation and clear on channel 3
    rst = 1'b1; step(); rst = 1'b0;
    toggle_i = 8'h08; rd_ch_i = 3;
    for (int i = 0; i < 20; i++) step();
    chk("sat_cnt3", 32'(cnt_o), ED ? 1 : 15);
    clr_cnt_i = 1'b1; step();
    clr_cnt_i = 1'b0; toggle_i = '0;
    step(); step();
    chk("clr_cnt3", 32'(cnt_o), 0);
    // async reset mid-run from AUTO with q=5A
    rst = 1'b1; toggle_i = '0; step(); rst = 1'b0;
    div_i = 1000; toggle_i = 8'h5A;
    for (int c = 0; c < CH; c++) cfg(c, 3);
    step();
    for (int c = 0; c < CH; c++) cfg(c, 2);
    chk("pre_async_q", 32'(q_o), 32'h5A);
    #2 rst = 1'b1;
    #1 model_reset();
    chk("async_q", 32'(q_o), 0);
    chk("async_tick", 32'(tick_o), 0);
    chk("async_cnt", 32'(cnt_o), 0);
    #1 rst = 1'b0; toggle_i = 8'hFF;
    step();
    chk("async_modes_manual", 32'(q_o), 32'hFF);
    // randomized phase
    div_i = 2;
    for (int i = 0; i < 1500; i++) begin
      toggle_i = CH'($urandom);
      cfg_we_i = ($urandom_range(0, 3) == 0);
      cfg_ch_i = CHW'($urandom);
      cfg_mode_i = 2'($urandom);
      if ($urandom_range(0, 15) == 0) div_i = DW'($urandom_range(0, 5));
      clr_cnt_i = ($urandom_range(0, 31) == 0);
      rd_ch_i = CHW'($urandom);
      step();
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1'b1;
        #1 model_reset();
        cmp();
        #1 rst = 1'b0;
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
